jk_bank_arbiter: RTL

//  Controller for a bank of WIDTH external jk_ff instances (one per bit): arbitrates
//  bit-operation commands from two requesters (A, B) round-robin and sequences each

---
 rtl/jk_bank_arbiter_if.sv | 34 +++
 rtl/jk_bank_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter_if.sv
//------------------------------------------------------------------------------
// jk_bank_arbiter_if : requester handshake and status bundle for jk_bank_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface jk_bank_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             a_valid;
  logic             a_ready;
  logic [1:0]       a_op;
  logic [WIDTH-1:0] a_mask;
  logic             b_valid;
  logic             b_ready;
  logic [1:0]       b_op;
  logic [WIDTH-1:0] b_mask;
  logic             busy;
  logic             done;
  logic             err;
  logic             done_src;

  modport master (
    output a_valid, a_op, a_mask, b_valid, b_op, b_mask,
    input  a_ready, b_ready, busy, done, err, done_src
  );

  modport slave (
    input  a_valid, a_op, a_mask, b_valid, b_op, b_mask,
    output a_ready, b_ready, busy, done, err, done_src
  );
endinterface

`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
//------------------------------------------------------------------------------
// jk_bank_arbiter : round-robin A/B arbiter driving a jk_ff bank for one clock
//                   per command, with q readback verification.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jk_bank_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_arbiter_if.slave req,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  input  logic [WIDTH-1:0] q_in_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] exp_q;
  logic             src_q;
  logic             last_grant_q;
  logic             done_q;
  logic             err_q;
  logic             done_src_q;

  logic             grant_b;
  logic             accept;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] mask_sel;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] exp_d;

  always_comb begin
    grant_b = req.b_valid;
    // On contention the requester not served last wins (last_grant 1 = B).
    if (req.a_valid && req.b_valid) begin
      grant_b = ~last_grant_q;
    end
    op_sel   = grant_b ? req.b_op   : req.a_op;
    mask_sel = grant_b ? req.b_mask : req.a_mask;
    j_d      = {WIDTH{op_sel[1]}} & mask_sel;
    k_d      = {WIDTH{op_sel[0]}} & mask_sel;
    // JK characteristic equation gives the value each bit must land on.
    exp_d    = (j_d & ~q_in_i) | (~k_d & q_in_i);
  end

  assign req.a_ready  = (state_q == IDLE) && req.a_valid && !grant_b;
  assign req.b_ready  = (state_q == IDLE) && req.b_valid && grant_b;
  assign accept       = req.a_ready || req.b_ready;
  assign req.busy     = (state_q != IDLE);
  assign req.done     = done_q;
  assign req.err      = err_q;
  assign req.done_src = done_src_q;
  assign j_o          = j_q;
  assign k_o          = k_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      j_q          <= '0;
      k_q          <= '0;
      exp_q        <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      done_src_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (accept) begin
            j_q          <= j_d;
            k_q          <= k_d;
            exp_q        <= exp_d;
            src_q        <= grant_b;
            last_grant_q <= grant_b;
            state_q      <= DRIVE;
          end
        end
        DRIVE: begin
          j_q     <= '0;
          k_q     <= '0;
          state_q <= CHECK;
        end
        CHECK: begin
          done_q     <= 1'b1;
          err_q      <= (q_in_i != exp_q);
          done_src_q <= src_q;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
